// File: rtl/pe_pkg.sv
// Shared sizing for the systolic array: operand width and derived partial-sum widths.
package pe_pkg;

  localparam int unsigned PE_WIDTH   = 8;
  localparam int unsigned PSUM_IN_W  = 2 * PE_WIDTH;
  localparam int unsigned PSUM_OUT_W = 2 * PE_WIDTH + 1;

  function automatic int unsigned psum_in_width(input int unsigned w);
    return 2 * w;
  endfunction

  function automatic int unsigned psum_out_width(input int unsigned w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/pe_mac.sv
// Combinational multiply-accumulate: psum_o = {1'b0,psum_i} + a_i*b_i, full width, no wrap.
module pe_mac
  import pe_pkg::*;
#(
  parameter int unsigned WIDTH = PE_WIDTH
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic [2*WIDTH-1:0] psum_i,
  output logic [2*WIDTH:0]   psum_o
);

  logic [2*WIDTH-1:0] prod;

  always_comb begin
    prod   = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
    psum_o = {1'b0, psum_i} + {1'b0, prod};
  end

endmodule

// File: rtl/processing_element.sv
// Systolic MAC cell: registers the activation/weight for forwarding and the accumulated partial sum.
module processing_element
  import pe_pkg::*;
#(
  parameter int unsigned WIDTH = PE_WIDTH
) (
  input  logic               CLK,
  input  logic               SYNC_RST,
  input  logic               EN,
  input  logic [WIDTH-1:0]   Input,
  input  logic [WIDTH-1:0]   Weight,
  input  logic [2*WIDTH-1:0] PsumIn,
  output logic [WIDTH-1:0]   ToRight,
  output logic [WIDTH-1:0]   ToDown,
  output logic [2*WIDTH:0]   PsumOut
);

  logic [WIDTH-1:0] right_q, right_d;
  logic [WIDTH-1:0] down_q,  down_d;
  logic [2*WIDTH:0] psum_q,  psum_d;
  logic [2*WIDTH:0] mac_sum;

  pe_mac #(.WIDTH(WIDTH)) u_mac (
    .a_i    (Input),
    .b_i    (Weight),
    .psum_i (PsumIn),
    .psum_o (mac_sum)
  );

  always_comb begin
    right_d = right_q;
    down_d  = down_q;
    psum_d  = psum_q;
    if (EN) begin
      right_d = Input;
      down_d  = Weight;
      psum_d  = mac_sum;
    end
  end

  // Reset wins over EN; clear happens only at the clock edge.
  always_ff @(posedge CLK) begin
    if (SYNC_RST) begin
      right_q <= '0;
      down_q  <= '0;
      psum_q  <= '0;
    end else begin
      right_q <= right_d;
      down_q  <= down_d;
      psum_q  <= psum_d;
    end
  end

  assign ToRight = right_q;
  assign ToDown  = down_q;
  assign PsumOut = psum_q;

endmodule

// File: tb/tb_processing_element.sv
// Directed, table-driven bench for processing_element with a few hand-written timing sequences.
module tb_processing_element;

  localparam int unsigned W = 8;

  logic           CLK = 1'b0;
  logic           SYNC_RST = 1'b1;
  logic           EN = 1'b0;
  logic [W-1:0]   Input = '0;
  logic [W-1:0]   Weight = '0;
  logic [2*W-1:0] PsumIn = '0;
  logic [W-1:0]   ToRight;
  logic [W-1:0]   ToDown;
  logic [2*W:0]   PsumOut;

  int unsigned errors = 0;
  int unsigned checks = 0;

  processing_element #(.WIDTH(W)) dut (
    .CLK      (CLK),
    .SYNC_RST (SYNC_RST),
    .EN       (EN),
    .Input    (Input),
    .Weight   (Weight),
    .PsumIn   (PsumIn),
    .ToRight  (ToRight),
    .ToDown   (ToDown),
    .PsumOut  (PsumOut)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic           rst;
    logic           en;
    logic [W-1:0]   in;
    logic [W-1:0]   wt;
    logic [2*W-1:0] ps;
    logic [W-1:0]   exp_r;
    logic [W-1:0]   exp_d;
    logic [2*W:0]   exp_p;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic en, input logic [W-1:0] in,
                       input logic [W-1:0] wt, input logic [2*W-1:0] ps);
    @(negedge CLK);
    SYNC_RST = rst;
    EN       = en;
    Input    = in;
    Weight   = wt;
    PsumIn   = ps;
    @(posedge CLK);
    #1;
  endtask

  initial begin
    //         rst   en    in   wt   ps      right down psum
    vecs[0]  = '{1'b1, 1'b1,   5,   3,     0,    0,   0,      0};
    vecs[1]  = '{1'b1, 1'b1,   5,   3,     0,    0,   0,      0};
    vecs[2]  = '{1'b0, 1'b1,   5,   3,     0,    5,   3,     15};
    vecs[3]  = '{1'b0, 1'b1,   7,   2,    15,    7,   2,     29};
    vecs[4]  = '{1'b0, 1'b0,   9,   9,   100,    7,   2,     29};
    vecs[5]  = '{1'b0, 1'b0,   9,   9,   100,    7,   2,     29};
    vecs[6]  = '{1'b0, 1'b0,   9,   9,   100,    7,   2,     29};
    vecs[7]  = '{1'b0, 1'b1, 255, 255, 65535,  255, 255, 130560};
    vecs[8]  = '{1'b1, 1'b1, 200, 100,  1000,    0,   0,      0};
    vecs[9]  = '{1'b0, 1'b1,  10,  20,   300,   10,  20,    500};
    vecs[10] = '{1'b0, 1'b1,   0, 255, 65535,    0, 255,  65535};
    vecs[11] = '{1'b0, 1'b1, 255,   0,     1,  255,   0,      1};
    vecs[12] = '{1'b1, 1'b0,   3,   3,     3,    0,   0,      0};
    vecs[13] = '{1'b0, 1'b0,   4,   4,     4,    0,   0,      0};
    vecs[14] = '{1'b0, 1'b1,  16,  16, 65535,   16,  16,  65791};
    vecs[15] = '{1'b0, 1'b1, 128,   2,     0,  128,   2,    256};

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].in, vecs[i].wt, vecs[i].ps);
      check("ToRight", i, 32'(ToRight), 32'(vecs[i].exp_r));
      check("ToDown",  i, 32'(ToDown),  32'(vecs[i].exp_d));
      check("PsumOut", i, 32'(PsumOut), 32'(vecs[i].exp_p));
    end

    // Outputs are registered: changing inputs mid-cycle must not disturb them.
    @(negedge CLK);
    Input = 8'd99; Weight = 8'd77; PsumIn = 16'd1234; EN = 1'b1; SYNC_RST = 1'b0;
    #2;
    check("NoCombPath_R", 0, 32'(ToRight), 32'd128);
    check("NoCombPath_P", 0, 32'(PsumOut), 32'd256);
    @(posedge CLK); #1;
    check("CaptureAfterChange", 0, 32'(PsumOut), 32'd8857);

    // Reset asserted mid-cycle must not clear until the next edge.
    @(negedge CLK);
    SYNC_RST = 1'b1;
    #2;
    check("NoAsyncClear_R", 0, 32'(ToRight), 32'd99);
    check("NoAsyncClear_P", 0, 32'(PsumOut), 32'd8857);
    @(posedge CLK); #1;
    check("SyncClear_R", 0, 32'(ToRight), 32'd0);
    check("SyncClear_P", 0, 32'(PsumOut), 32'd0);

    // Release reset with EN=0: stays zero, then resumes on first EN edge.
    drive(1'b0, 1'b0, 8'd6, 8'd6, 16'd6);
    check("PostRstHold_P", 0, 32'(PsumOut), 32'd0);
    drive(1'b0, 1'b1, 8'd6, 8'd6, 16'd6);
    check("Resume_R", 0, 32'(ToRight), 32'd6);
    check("Resume_P", 0, 32'(PsumOut), 32'd42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
